// File: rtl/split_pkg.sv
// ============================================================================
//  split_pkg : shared state encoding for the split controller
//  Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package split_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_e;

endpackage : split_pkg

`default_nettype wire

// File: rtl/split_core.sv
// ============================================================================
//  split_core : half-period counter and output toggle
//  Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module split_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear,
   input  logic [WIDTH-1:0] const_val,
   output logic             out,
   output logic [WIDTH-1:0] out_counter,
   output logic             tc,
   output logic             fall_tc
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;

   // const_val arrives already substituted, so it is never zero here
   assign tc          = enable && (cnt_q == (const_val - WIDTH'(1)));
   assign fall_tc     = tc && out_q;
   assign out         = out_q;
   assign out_counter = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      out_d = out_q;
      if (clear) begin
         cnt_d = '0;
         out_d = 1'b0;
      end else if (tc) begin
         cnt_d = '0;
         out_d = !out_q;
      end else if (enable) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

endmodule : split_core

`default_nettype wire

// File: rtl/split_ctrl.sv
// ============================================================================
//  split_ctrl : run-time controller for the divide-by-CONST toggle datapath
//  Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module split_ctrl
   import split_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEF_CONST = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_const,
   input  logic [WIDTH-1:0] cfg_pulses,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             done,
   output logic             out,
   output logic [WIDTH-1:0] out_counter
);

   localparam logic [WIDTH-1:0] c_def_const = WIDTH'(DEF_CONST);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] act_const_q, act_const_d;
   logic [WIDTH-1:0] act_pulses_q, act_pulses_d;
   logic             pend_vld_q, pend_vld_d;
   logic [WIDTH-1:0] pend_const_q, pend_const_d;
   logic [WIDTH-1:0] pend_pulses_q, pend_pulses_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             done_q, done_d;

   logic             xfer;
   logic [WIDTH-1:0] const_eff;
   logic             pulses_end;
   logic             tc;
   logic             fall_tc;

   assign cfg_ready  = !pend_vld_q;
   assign xfer       = cfg_valid && cfg_ready;
   assign const_eff  = (act_const_q == '0) ? WIDTH'(1) : act_const_q;
   assign pulses_end = (act_pulses_q != '0) && ((period_q + WIDTH'(1)) == act_pulses_q);
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;

   split_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk         (clk),
      .rst         (rst),
      .enable      (state_q != ST_IDLE),
      .clear       (state_q == ST_IDLE),
      .const_val   (const_eff),
      .out         (out),
      .out_counter (out_counter),
      .tc          (tc),
      .fall_tc     (fall_tc)
   );

   // A stop that lands on a falling TC is already on a period boundary,
   // so it finishes immediately instead of running one more period.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (fall_tc && (stop || pulses_end)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (stop) begin
               state_d = ST_STOPPING;
            end
         end
         ST_STOPPING: begin
            if (fall_tc) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      act_const_d   = act_const_q;
      act_pulses_d  = act_pulses_q;
      pend_vld_d    = pend_vld_q;
      pend_const_d  = pend_const_q;
      pend_pulses_d = pend_pulses_q;
      period_d      = period_q;
      if (state_q == ST_IDLE) begin
         period_d = '0;
         if (xfer) begin
            act_const_d  = cfg_const;
            act_pulses_d = cfg_pulses;
         end
      end else begin
         if (fall_tc) period_d = period_q + WIDTH'(1);
         if (tc && pend_vld_q) begin
            act_const_d  = pend_const_q;
            act_pulses_d = pend_pulses_q;
            pend_vld_d   = 1'b0;
         end else if (xfer) begin
            pend_vld_d    = 1'b1;
            pend_const_d  = cfg_const;
            pend_pulses_d = cfg_pulses;
         end
      end
      if (state_d == ST_IDLE) pend_vld_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         act_const_q   <= c_def_const;
         act_pulses_q  <= '0;
         pend_vld_q    <= 1'b0;
         pend_const_q  <= '0;
         pend_pulses_q <= '0;
         period_q      <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         act_const_q   <= act_const_d;
         act_pulses_q  <= act_pulses_d;
         pend_vld_q    <= pend_vld_d;
         pend_const_q  <= pend_const_d;
         pend_pulses_q <= pend_pulses_d;
         period_q      <= period_d;
         done_q        <= done_d;
      end
   end

endmodule : split_ctrl

`default_nettype wire
